tlcd_font_loader: RTL and testbench
===================================

TLCD_FONT_LOADER -- requirements
Module: tlcd_font_loader

Interface
REQ-001 The block SHALL provide parameter POWERON_CYC, default 750000, meaning idle cycles after reset before the first LCD write (15 ms at 50 MHz).
REQ-002 The block SHALL provide parameter SETUP_CYC, default 2, meaning cycles RS/DATA are stable with E low before E rises.
REQ-003 The block SHALL provide parameter PULSE_CYC, default 12, meaning cycles E is held high per write.
REQ-004 The block SHALL provide parameter HOLD_CYC, default 2, meaning cycles RS/DATA are held with E low after E falls.
REQ-005 The block SHALL provide parameter GAP_CYC, default 2500, meaning LCD busy wait after each write (50 us at 50 MHz).
REQ-006 The block SHALL provide port CLK, input, 1 bit, meaning the single system clock; all logic is on its rising edge.
REQ-007 The block SHALL provide port RESETN, input, 1 bit, meaning a synchronous, active-high reset sampled on the rising edge of CLK.
REQ-008 The block SHALL provide ports TLCD_E, TLCD_RS and TLCD_RW, each an output of 1 bit, meaning the LCD enable strobe, register select (0 = command, 1 = data) and read/write (always 0).
REQ-009 The block SHALL provide port TLCD_DATA, output, 8 bits, meaning the LCD data bus.
REQ-010 The block SHALL provide port DONE, output, 1 bit, meaning that all CGRAM writes are complete; it is sticky until reset.

Function
REQ-011 The write sequence SHALL be, in order:
- Function set 0x38 (RS=0)
- CGRAM address set 0x40 (RS=0)
- 64 data bytes (RS=1): glyph 0..7, rows 0..7 each, row-major.
REQ-012 The top-level FSM SHALL have states PWR_WAIT, FSET, CGADDR, DATA and FINISH.
REQ-013 Top-level FSM transitions SHALL be:
- PWR_WAIT to FSET after POWERON_CYC cycles
- FSET to CGADDR, and CGADDR to DATA, each after its write completes
- DATA to FINISH after the write of byte index 63 completes.
REQ-014 Each write SHALL run through sub-phases SETUP, PULSE, HOLD and GAP, lasting SETUP_CYC, PULSE_CYC, HOLD_CYC and GAP_CYC cycles respectively, so one write takes exactly SETUP_CYC+PULSE_CYC+HOLD_CYC+GAP_CYC cycles.
REQ-015 TLCD_E SHALL be 1 only during PULSE.
REQ-016 TLCD_RS and TLCD_DATA SHALL be constant from the first SETUP cycle through the last HOLD cycle of a write.
REQ-017 Data bytes SHALL be {3'b000, row[4:0]}, where row is the font ROM output for index {glyph[2:0], row[2:0]}.
REQ-018 A 6-bit byte index SHALL count 0 to 63 and SHALL NOT wrap; reaching 63 ends DATA.
REQ-019 In FINISH:
- DONE=1 and TLCD_E=0
- TLCD_RS=0 and TLCD_DATA=0x00
- no further writes until reset.
REQ-020 DONE SHALL rise exactly one cycle after the final GAP cycle, with total latency from reset release equal to POWERON_CYC + 66×(SETUP_CYC+PULSE_CYC+HOLD_CYC+GAP_CYC) cycles, ±1.
REQ-021 TLCD_RW SHALL be 0 at all times.
REQ-022 Every parameter SHALL be at least 1, and each cycle counter SHALL be wide enough for its parameter value.

Reset
REQ-023 While RESETN=1:
- state SHALL be PWR_WAIT
- counters and byte index SHALL be 0
- DONE=0, TLCD_E=0, TLCD_RS=0, TLCD_RW=0, TLCD_DATA=0x00.
REQ-024 Reset asserted mid-write, including during PULSE, SHALL force TLCD_E=0 on the next edge and restart the whole sequence from PWR_WAIT after release.

Structure
REQ-025 The LCD command codes (0x38, 0x40), glyph count (8), rows per glyph (8) and FSM state encodings SHALL reside in shared package tlcd_pkg, together with the command codes used by tlcd_controller.
REQ-026 Glyph bitmaps SHALL live in sub-module tlcd_font_rom: combinational, 6-bit address in, 5-bit row out, 64 entries.
REQ-027 Glyph 0 SHALL be a full block, with every row equal to 0x1F.

Verification (bench uses POWERON_CYC=10, SETUP_CYC=1, PULSE_CYC=2, HOLD_CYC=1, GAP_CYC=4)
REQ-028 Reset then release -> exactly 66 E pulses, each 2 cycles wide; first command 0x38 with RS=0, second 0x40 with RS=0; DONE=1 at cycle 10+66×8=538 (±1).
REQ-029 Capture on each E falling edge -> data writes 1..8 read 0x1F with RS=1, and write 64 equals {3'b000, ROM[63]}.
REQ-030 At each E rising and falling edge -> RS and DATA are unchanged for SETUP/HOLD cycles around it, and RW=0 throughout.
REQ-031 Assert RESETN during the PULSE of data byte 20 -> E=0 on the next edge and DONE=0; after release, the full 66-write sequence repeats from 0x38.
REQ-032 Run 200 cycles after DONE -> no E activity, DATA=0x00, DONE held at 1.

Source files
------------

// File: rtl/tlcd_pkg.sv
// Shared definitions for the character-LCD blocks: command codes, font geometry
// and the state/phase encodings of the CGRAM font loader.
package tlcd_pkg;

    localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_CGRAM_ADDR   = 8'h40;  // CGRAM address 0
    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
    localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
    localparam logic [7:0] CMD_DDRAM_ADDR   = 8'h80;

    localparam int GLYPH_COUNT = 8;
    localparam int GLYPH_ROWS  = 8;
    localparam int FONT_BYTES  = GLYPH_COUNT * GLYPH_ROWS;

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        FSET     = 3'd1,
        CGADDR   = 3'd2,
        DATA     = 3'd3,
        FINISH   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_PULSE = 2'd1,
        PH_HOLD  = 2'd2,
        PH_GAP   = 2'd3
    } phase_t;

endpackage

// File: rtl/tlcd_font_rom.sv
// Combinational 8-glyph 5x8 font: address {glyph, row}, 5-bit row bitmap out.
module tlcd_font_rom
    import tlcd_pkg::*;
(
    input  logic [5:0] addr,
    output logic [4:0] row
);

    // rows listed top (row 0) to bottom (row 7)
    logic [0:7][4:0] glyph;

    always_comb begin
        glyph = '0;
        case (addr[5:3])
            3'd0: glyph = {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F};
            3'd1: glyph = {5'h00, 5'h0A, 5'h1F, 5'h1F, 5'h0E, 5'h04, 5'h00, 5'h00};
            3'd2: glyph = {5'h00, 5'h0A, 5'h0A, 5'h00, 5'h11, 5'h0E, 5'h00, 5'h00};
            3'd3: glyph = {5'h04, 5'h0E, 5'h0E, 5'h0E, 5'h1F, 5'h00, 5'h04, 5'h00};
            3'd4: glyph = {5'h04, 5'h0E, 5'h15, 5'h04, 5'h04, 5'h04, 5'h04, 5'h00};
            3'd5: glyph = {5'h15, 5'h0A, 5'h15, 5'h0A, 5'h15, 5'h0A, 5'h15, 5'h0A};
            3'd6: glyph = {5'h06, 5'h09, 5'h09, 5'h06, 5'h00, 5'h00, 5'h00, 5'h00};
            3'd7: glyph = {5'h1F, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h15};
            default: glyph = '0;
        endcase
        row = glyph[addr[2:0]];
    end

endmodule

// File: rtl/tlcd_font_loader.sv
// Loads the 8 custom glyphs into LCD CGRAM after power-on: function set,
// CGRAM address, then 64 row bytes, each write timed as SETUP/PULSE/HOLD/GAP.
module tlcd_font_loader
    import tlcd_pkg::*;
#(
    parameter int POWERON_CYC = 750000,
    parameter int SETUP_CYC   = 2,
    parameter int PULSE_CYC   = 12,
    parameter int HOLD_CYC    = 2,
    parameter int GAP_CYC     = 2500
) (
    input  logic       CLK,
    input  logic       RESETN,
    output logic       TLCD_E,
    output logic       TLCD_RS,
    output logic       TLCD_RW,
    output logic [7:0] TLCD_DATA,
    output logic       DONE,
    output state_t     dbg_state
);

    localparam int MAX_A   = (POWERON_CYC > GAP_CYC) ? POWERON_CYC : GAP_CYC;
    localparam int MAX_B   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_C   = (MAX_B > HOLD_CYC) ? MAX_B : HOLD_CYC;
    localparam int CNT_MAX = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t           state, next_state;
    phase_t           phase, next_phase;
    logic [CNT_W-1:0] cnt, next_cnt, phase_last;
    logic [5:0]       idx, next_idx;
    logic [4:0]       rom_row;
    logic             writing;

    tlcd_font_rom u_rom (
        .addr (idx),
        .row  (rom_row)
    );

    always_ff @(posedge CLK) begin
        if (RESETN) begin
            state <= PWR_WAIT;
            phase <= PH_SETUP;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= next_state;
            phase <= next_phase;
            cnt   <= next_cnt;
            idx   <= next_idx;
        end
    end

    always_comb begin
        phase_last = CNT_W'(SETUP_CYC - 1);
        case (phase)
            PH_SETUP: phase_last = CNT_W'(SETUP_CYC - 1);
            PH_PULSE: phase_last = CNT_W'(PULSE_CYC - 1);
            PH_HOLD:  phase_last = CNT_W'(HOLD_CYC - 1);
            PH_GAP:   phase_last = CNT_W'(GAP_CYC - 1);
            default:  phase_last = CNT_W'(SETUP_CYC - 1);
        endcase
    end

    always_comb begin
        next_state = state;
        next_phase = phase;
        next_cnt   = cnt + CNT_W'(1);
        next_idx   = idx;
        case (state)
            PWR_WAIT: begin
                if (cnt == CNT_W'(POWERON_CYC - 1)) begin
                    next_state = FSET;
                    next_phase = PH_SETUP;
                    next_cnt   = '0;
                end
            end
            FSET, CGADDR, DATA: begin
                if (cnt == phase_last) begin
                    next_cnt = '0;
                    case (phase)
                        PH_SETUP: next_phase = PH_PULSE;
                        PH_PULSE: next_phase = PH_HOLD;
                        PH_HOLD:  next_phase = PH_GAP;
                        default: begin
                            // end of GAP: the write is complete
                            next_phase = PH_SETUP;
                            if (state == FSET) begin
                                next_state = CGADDR;
                            end else if (state == CGADDR) begin
                                next_state = DATA;
                            end else if (idx == 6'd63) begin
                                next_state = FINISH;
                            end else begin
                                next_idx = idx + 6'd1;
                            end
                        end
                    endcase
                end
            end
            FINISH: next_cnt = cnt;
            default: next_state = PWR_WAIT;
        endcase
    end

    // bus values are held for the whole write, GAP included
    always_comb begin
        writing   = (state == FSET) || (state == CGADDR) || (state == DATA);
        TLCD_E    = writing && (phase == PH_PULSE);
        TLCD_RS   = (state == DATA);
        TLCD_RW   = 1'b0;
        DONE      = (state == FINISH);
        dbg_state = state;
        TLCD_DATA = 8'h00;
        case (state)
            FSET:    TLCD_DATA = CMD_FUNCTION_SET;
            CGADDR:  TLCD_DATA = CMD_CGRAM_ADDR;
            DATA:    TLCD_DATA = {3'b000, rom_row};
            default: TLCD_DATA = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tlcd_font_loader.sv
// Directed bench for tlcd_font_loader with a write scoreboard fed at reset release
// and drained on every E falling edge.
module tb_tlcd_font_loader;
    import tlcd_pkg::*;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b1;
    logic       TLCD_E, TLCD_RS, TLCD_RW, DONE;
    logic [7:0] TLCD_DATA;
    state_t     dbg_state;

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];

    int   rise_cnt = 0;
    int   fall_cnt = 0;
    int   width = 0;
    logic prev_e = 1'b0;
    logic [8:0] prev_bus = '0;
    logic [8:0] pulse_bus = '0;

    tlcd_font_loader #(
        .POWERON_CYC (10),
        .SETUP_CYC   (1),
        .PULSE_CYC   (2),
        .HOLD_CYC    (1),
        .GAP_CYC     (4)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .TLCD_E    (TLCD_E),
        .TLCD_RS   (TLCD_RS),
        .TLCD_RW   (TLCD_RW),
        .TLCD_DATA (TLCD_DATA),
        .DONE      (DONE),
        .dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] font_row(input int i);
        logic [39:0] g;
        case (i / 8)
            0: g = {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F};
            1: g = {5'h00, 5'h0A, 5'h1F, 5'h1F, 5'h0E, 5'h04, 5'h00, 5'h00};
            2: g = {5'h00, 5'h0A, 5'h0A, 5'h00, 5'h11, 5'h0E, 5'h00, 5'h00};
            3: g = {5'h04, 5'h0E, 5'h0E, 5'h0E, 5'h1F, 5'h00, 5'h04, 5'h00};
            4: g = {5'h04, 5'h0E, 5'h15, 5'h04, 5'h04, 5'h04, 5'h04, 5'h00};
            5: g = {5'h15, 5'h0A, 5'h15, 5'h0A, 5'h15, 5'h0A, 5'h15, 5'h0A};
            6: g = {5'h06, 5'h09, 5'h09, 5'h06, 5'h00, 5'h00, 5'h00, 5'h00};
            default: g = {5'h1F, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h15};
        endcase
        return g[39 - 5 * (i % 8) -: 5];
    endfunction

    task automatic push_sequence();
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h40});
        for (int i = 0; i < 64; i++) exp_q.push_back({1'b1, 3'b000, font_row(i)});
    endtask

    // bus monitor: pulse width, setup/hold stability, RW, scoreboard pops
    always @(negedge CLK) begin
        if (RESETN) begin
            rise_cnt = 0;
            fall_cnt = 0;
            width    = 0;
            prev_e   = 1'b0;
            prev_bus = {TLCD_RS, TLCD_DATA};
        end else begin
            chk("rw_low", 32'(TLCD_RW), 32'd0);
            if (TLCD_E && !prev_e) begin
                rise_cnt++;
                width     = 1;
                pulse_bus = {TLCD_RS, TLCD_DATA};
                chk("setup_stable", 32'({TLCD_RS, TLCD_DATA}), 32'(prev_bus));
            end else if (TLCD_E && prev_e) begin
                width++;
                chk("pulse_stable", 32'({TLCD_RS, TLCD_DATA}), 32'(pulse_bus));
            end else if (!TLCD_E && prev_e) begin
                fall_cnt++;
                chk("pulse_width", 32'(width), 32'd2);
                chk("hold_stable", 32'({TLCD_RS, TLCD_DATA}), 32'(pulse_bus));
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(fall_cnt), 32'd0);
                end else begin
                    chk($sformatf("write_%0d", fall_cnt), 32'(pulse_bus), 32'(exp_q.pop_front()));
                end
            end
            prev_e   = TLCD_E;
            prev_bus = {TLCD_RS, TLCD_DATA};
        end
    end

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (n < 2000) begin
            @(posedge CLK);
            n++;
            #1;
            if (DONE) break;
        end
        chk({tag, "_done_latency_ok"}, 32'(n >= 537 && n <= 539), 32'd1);
        chk({tag, "_done_cycle"}, 32'(n), 32'd538);
    endtask

    task automatic idle_after_done(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK);
            #1;
            chk({tag, "_idle_e"}, 32'(TLCD_E), 32'd0);
            chk({tag, "_idle_data"}, 32'(TLCD_DATA), 32'd0);
            chk({tag, "_idle_done"}, 32'(DONE), 32'd1);
        end
        chk({tag, "_idle_rs"}, 32'(TLCD_RS), 32'd0);
        chk({tag, "_state_finish"}, 32'(dbg_state), 32'(FINISH));
        chk({tag, "_pulse_count"}, 32'(rise_cnt), 32'd66);
        chk({tag, "_fall_count"}, 32'(fall_cnt), 32'd66);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        // reset values
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_e", 32'(TLCD_E), 32'd0);
        chk("rst_rs", 32'(TLCD_RS), 32'd0);
        chk("rst_rw", 32'(TLCD_RW), 32'd0);
        chk("rst_data", 32'(TLCD_DATA), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(PWR_WAIT));

        // full load sequence
        push_sequence();
        RESETN = 1'b0;
        wait_done("run1");
        idle_after_done("run1");

        // reset during the E pulse of data byte 20 (write 23)
        RESETN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        push_sequence();
        RESETN = 1'b0;
        n = 0;
        while (n < 1000) begin
            @(negedge CLK);
            #1;
            n++;
            if (rise_cnt == 23) break;
        end
        chk("reach_byte20", 32'(rise_cnt), 32'd23);
        chk("byte20_e_high", 32'(TLCD_E), 32'd1);
        chk("byte20_bus", 32'({TLCD_RS, TLCD_DATA}), 32'({1'b1, 3'b000, font_row(20)}));
        RESETN = 1'b1;
        @(posedge CLK);
        #1;
        chk("midrst_e", 32'(TLCD_E), 32'd0);
        chk("midrst_done", 32'(DONE), 32'd0);
        chk("midrst_state", 32'(dbg_state), 32'(PWR_WAIT));
        repeat (2) @(posedge CLK);
        #1;
        push_sequence();
        RESETN = 1'b0;
        wait_done("run2");
        idle_after_done("run2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
